// File: rtl/led_pwm_driver_pkg.sv
// Shared constants for the LED PWM driver: config register map and blink FSM encoding.
package led_pwm_driver_pkg;

    localparam logic [1:0] ADDR_BRIGHT = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StShow = 2'd1,
        StHide = 2'd2
    } blink_state_e;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: a free-running prescaler producing a one-cycle tick, and a 4-bit PWM step counter.
module led_pwm_timebase
    import led_pwm_driver_pkg::*;
#(
    parameter int unsigned PWM_DIV = 390
) (
    input  logic       clock,
    input  logic       reset,
    output logic       tick,
    output logic [3:0] pwm_cnt
);

    localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [3:0]    pwm_cnt_q;

    assign tick    = (presc_q == PRESC_LAST);
    assign pwm_cnt = pwm_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                pwm_cnt_q <= pwm_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// Board LED driver: global PWM dimming plus per-group blinking, with a registered output stage.
module led_pwm_driver
    import led_pwm_driver_pkg::*;
#(
    parameter int unsigned PWM_DIV   = 390,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] leds_in,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic [23:0] leds_out,
    output logic        blink_phase
);

    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [3:0]    brightness_q;
    logic [2:0]    mask_q;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    act_sel_q;
    logic [BW-1:0] blink_cnt_q;
    logic [1:0]    unit_cnt_q;
    logic [23:0]   leds_out_q;
    logic [3:0]    pwm_cnt;
    logic          unused_tick;
    logic          unused_cfg;
    logic          mask_wr;
    logic          half_done;
    logic          pwm_on;
    logic [2:0]    group_vis;

    blink_state_e state_q, state_d;

    assign unused_cfg = ^cfg_data[7:4];

    led_pwm_timebase #(
        .PWM_DIV (PWM_DIV)
    ) u_timebase (
        .clock   (clock),
        .reset   (reset),
        .tick    (unused_tick),
        .pwm_cnt (pwm_cnt)
    );

    assign mask_wr   = cfg_we && (cfg_addr == ADDR_MASK);
    assign half_done = (blink_cnt_q == BLINK_LAST) && (unit_cnt_q == act_sel_q);
    assign sel_d     = (cfg_we && (cfg_addr == ADDR_PERIOD)) ? cfg_data[1:0] : sel_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brightness_q <= 4'd15;
            mask_q       <= '0;
            sel_q        <= '0;
        end else begin
            sel_q <= sel_d;
            if (cfg_we && (cfg_addr == ADDR_BRIGHT)) begin
                brightness_q <= cfg_data[3:0];
            end
            if (mask_wr) begin
                mask_q <= cfg_data[2:0];
            end
        end
    end

    // Half-period = (act_sel+1) runs of BLINK_DIV cycles; sel is only sampled at a restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            unit_cnt_q  <= '0;
            act_sel_q   <= '0;
        end else if (mask_wr || half_done) begin
            blink_cnt_q <= '0;
            unit_cnt_q  <= '0;
            act_sel_q   <= sel_d;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            unit_cnt_q  <= unit_cnt_q + 2'd1;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mask_wr) begin
            state_d = (cfg_data[2:0] != 3'b000) ? StShow : StIdle;
        end else if (half_done) begin
            case (state_q)
                StShow:  state_d = StHide;
                StHide:  state_d = StShow;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        blink_phase = (state_q != StHide);
    end

    always_comb begin
        if (brightness_q == 4'd15) begin
            pwm_on = 1'b1;
        end else begin
            pwm_on = (pwm_cnt < brightness_q);
        end
        group_vis = ~mask_q | {3{blink_phase}};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds_out_q <= '0;
        end else begin
            leds_out_q <= leds_in & {24{pwm_on}}
                        & {{8{group_vis[2]}}, {8{group_vis[1]}}, {8{group_vis[0]}}};
        end
    end

    assign leds_out = leds_out_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with PWM_DIV=2, BLINK_DIV=4 and a scoreboard queue.
module tb_led_pwm_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] leds_in = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic [23:0] leds_out;
    logic        blink_phase;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [24:0] exp;
        string       tag;
    } sb_item_t;

    sb_item_t sb[$];

    led_pwm_driver #(
        .PWM_DIV   (2),
        .BLINK_DIV (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .leds_in     (leds_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .leds_out    (leds_out),
        .blink_phase (blink_phase)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [23:0] leds, input logic phase);
        sb_item_t it;
        it.exp = {leds, phase};
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic check_out();
        sb_item_t    it;
        logic [24:0] obs;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed no entry, expected one queued");
        end else begin
            it  = sb.pop_front();
            obs = {leds_out, blink_phase};
            assert (obs === it.exp) n_pass++;
            else $error("FAIL %s: observed leds/phase %h, expected %h", it.tag, obs, it.exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        cycle();
        cfg_we   = 1'b0;
    endtask

    initial begin
        int lit;
        int dark;
        int other;

        // Reset state, visible before any clock edge.
        #1 reset = 1'b1;
        #1;
        check_val("reset_leds_async", 32'(leds_out), 32'h0);
        check_val("reset_phase_async", 32'(blink_phase), 32'h1);
        cycle();
        cycle();
        check_val("reset_leds_held", 32'(leds_out), 32'h0);

        // Full brightness pass-through, one cycle latency.
        reset   = 1'b0;
        leds_in = 24'hA5A5A5;
        for (int i = 0; i < 8; i++) begin
            expect_out("passthru", 24'hA5A5A5, 1'b1);
            cycle();
            check_out();
        end

        // Brightness 4 (upper data bits ignored): 8 of 32 cycles lit.
        leds_in = 24'hFFFFFF;
        cfg_write(2'd0, 8'hF4);
        lit   = 0;
        dark  = 0;
        other = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (leds_out === 24'hFFFFFF) lit++;
            else if (leds_out === 24'h0) dark++;
            else other++;
        end
        check_val("pwm4_lit", 32'(lit), 32'd8);
        check_val("pwm4_dark", 32'(dark), 32'd24);
        check_val("pwm4_other", 32'(other), 32'd0);

        // Brightness 0: always dark.
        cfg_write(2'd0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            leds_in = 24'($urandom);
            expect_out("bright0", 24'h0, 1'b1);
            cycle();
            check_out();
        end

        // Reserved address write has no effect; restore full brightness.
        cfg_write(2'd3, 8'h00);
        cfg_write(2'd0, 8'h0F);
        leds_in = 24'hFFFFFF;

        // Blink group 2 with sel=0: 4-cycle half-periods, starting lit.
        cfg_we   = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = 8'hFC;
        for (int i = 0; i <= 16; i++) begin
            expect_out("blink_sel0",
                       {((i == 0) || (((i - 1) / 4) % 2 == 0)) ? 8'hFF : 8'h00, 16'hFFFF},
                       ((i / 4) % 2) == 0);
            cycle();
            cfg_we = 1'b0;
            check_out();
        end

        // sel=1 mid half-period, then a mask write on the expiry edge.
        cfg_write(2'd2, 8'hFD);
        cycle();
        cycle();
        cfg_we   = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = 8'h04;
        for (int i = 0; i < 24; i++) begin
            expect_out("blink_sel1",
                       {((i == 0) || (((i - 1) / 8) % 2 == 0)) ? 8'hFF : 8'h00, 16'hFFFF},
                       ((i / 8) % 2) == 0);
            cycle();
            cfg_we = 1'b0;
            check_out();
        end

        // Reset in HIDE with brightness 4 acts immediately.
        cfg_write(2'd0, 8'h04);
        for (int i = 0; i < 4; i++) cycle();
        check_val("in_hide_before_reset", 32'(blink_phase), 32'h0);
        #2 reset = 1'b1;
        #1;
        check_val("midrun_reset_leds", 32'(leds_out), 32'h0);
        check_val("midrun_reset_phase", 32'(blink_phase), 32'h1);
        cycle();
        reset   = 1'b0;
        leds_in = 24'h3C5A96;
        for (int i = 0; i < 6; i++) begin
            expect_out("post_reset", 24'h3C5A96, 1'b1);
            cycle();
            check_out();
        end
        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter PWM_DIV, default 390: clock cycles per PWM step, legal range >=1.
REQ-002 Parameter BLINK_DIV, default 25_000_000: base blink half-period in clock cycles, legal range >=1.
REQ-003 Port clock, input, 1: system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port leds_in, input, 24: LED pattern from the LED register stage.
REQ-006 Port cfg_we, input, 1: config write strobe, one cycle per write.
REQ-007 Port cfg_addr, input, 2: config register select; 0 brightness, 1 blink mask, 2 blink period, 3 reserved.
REQ-008 Port cfg_data, input, 8: config write data.
REQ-009 Port leds_out, output, 24: registered drive to the board LED pins.
REQ-010 Port blink_phase, output, 1: 1 when blinking groups are lit (SHOW or IDLE), 0 in HIDE.

Function
REQ-011 The block SHALL hold brightness[3:0] = cfg_data[3:0] at address 0, mask[2:0] = cfg_data[2:0] at address 1, and sel[1:0] = cfg_data[1:0] at address 2; unused data bits and writes to address 3 SHALL be ignored.
REQ-012 A config write SHALL take effect in the cycle after cfg_we is sampled high.
REQ-013 The prescaler SHALL count 0..PWM_DIV-1 and wrap, and SHALL assert a one-cycle tick on each wrap.
REQ-014 pwm_cnt[3:0] SHALL increment on each tick and wrap 15->0.
REQ-015 pwm_on SHALL be 1 when brightness==15, 0 when brightness==0, and otherwise (pwm_cnt < brightness).
REQ-016 Brightness writes SHALL NOT clear the prescaler or pwm_cnt.
REQ-017 Mask bit g SHALL select LED group g: bit 0 covers leds[7:0], bit 1 covers leds[15:8], bit 2 covers leds[23:16].
REQ-018 The blink FSM SHALL have three states: IDLE (mask==0), SHOW, and HIDE.
REQ-019 Any mask write SHALL clear the blink counters and enter SHOW if the new mask is nonzero, or IDLE if it is zero.
REQ-020 The half-period SHALL be (sel+1)*BLINK_DIV cycles; at expiry, SHOW SHALL go to HIDE and HIDE SHALL go to SHOW, with the counters cleared.
REQ-021 A sel write SHALL apply from the next half-period boundary and SHALL NOT restart the counters.
REQ-022 If a mask write and a half-period expiry occur in the same cycle, the mask write SHALL take precedence.
REQ-023 leds_out[i] SHALL be registered as leds_in[i] & pwm_on & (~mask[group(i)] | blink_phase), giving one-cycle latency from leds_in.
REQ-024 The counters SHALL count freely; the block SHALL have no stall or handshake.

Reset
REQ-025 While reset is high: leds_out=0, brightness=15, mask=0, sel=0, prescaler=0, pwm_cnt=0, blink counters=0, FSM in IDLE, blink_phase=1.
REQ-026 A reset asserted mid-blink or mid-PWM period SHALL take effect immediately without waiting for a clock edge.
REQ-027 After reset deasserts, leds_out SHALL equal leds_in delayed by one cycle (full brightness, no blink).

Structure
REQ-028 A shared package SHALL hold the config address constants (ADDR_BRIGHT=0, ADDR_MASK=1, ADDR_PERIOD=2) and the FSM state encoding.
REQ-029 The prescaler and pwm_cnt SHALL be implemented in sub-module led_pwm_timebase, with outputs tick and pwm_cnt.
REQ-030 The blink FSM, config registers and output register SHALL be implemented in the top module.

Verification (PWM_DIV=2, BLINK_DIV=4)
REQ-031 Reset, then leds_in=24'hA5A5A5 -> leds_out=24'hA5A5A5 one cycle later, and it SHALL stay constant.
REQ-032 Brightness=4, leds_in=24'hFFFFFF -> over a 32-cycle PWM period, leds_out is 24'hFFFFFF for exactly 8 cycles and 0 for 24 cycles.
REQ-033 Brightness=0 -> leds_out=0 at all times regardless of leds_in.
REQ-034 Mask=3'b100, sel=0, leds_in=24'hFFFFFF -> leds_out[23:16] alternates every 4 cycles starting lit, and leds_out[15:0] stays 16'hFFFF.
REQ-035 Sel=1 with blinking active, and a mask write coincident with half-period expiry -> the FSM restarts in SHOW, the expiry is dropped, and subsequent half-periods are 8 cycles.
REQ-036 Reset asserted during HIDE with brightness=4 -> leds_out=0 immediately, and after release leds_out follows leds_in at full brightness with blink_phase=1.
